rng_share_arb: RTL

//  Shares one 10-bit maximal-length LFSR random source between N_REQ consumers (mutation/site samplers).

---
 rtl/rng_pkg.sv | 22 ++
 rtl/lfsr_core.sv | 42 ++++
 rtl/rng_share_arb.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/rng_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rng_pkg
//  Brief    : Shared constants and FSM encoding for the shared random source
//  Revision : 1.0  initial release
// ============================================================================
package rng_pkg;

    localparam int RNG_WIDTH  = 10;
    // Taps for x^10 + x^7 + 1 (maximal length, period 1023)
    localparam int RNG_TAP_HI = 9;
    localparam int RNG_TAP_LO = 6;
    localparam logic [RNG_WIDTH-1:0] RNG_SEED_DEFAULT = 10'h001;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        RESEED = 2'd1,
        WARM   = 2'd2
    } state_t;

endpackage : rng_pkg
`default_nettype wire

// File: rtl/lfsr_core.sv
`default_nettype none
// ============================================================================
//  Module   : lfsr_core
//  Brief    : Fibonacci LFSR with step/load controls and an all-zero guard
//  Revision : 1.0  initial release
// ============================================================================
module lfsr_core
    import rng_pkg::*;
#(
    parameter int              WIDTH = RNG_WIDTH,
    parameter logic [WIDTH-1:0] SEED  = RNG_SEED_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             step_en,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q
);

    // Zero is the lock-up state, so both seed sources are remapped to 1
    localparam logic [WIDTH-1:0] c_seed = (SEED == '0) ? WIDTH'(1) : SEED;

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_load_val;

    assign w_load_val = (load_val == '0) ? WIDTH'(1) : load_val;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= c_seed;
        end else if (load_en) begin
            r_q <= w_load_val;
        end else if (step_en) begin
            r_q <= {r_q[WIDTH-2:0], r_q[RNG_TAP_HI] ^ r_q[RNG_TAP_LO]};
        end
    end

    assign q = r_q;

endmodule : lfsr_core
`default_nettype wire

// File: rtl/rng_share_arb.sv
`default_nettype none
// ============================================================================
//  Module   : rng_share_arb
//  Brief    : Round-robin sharing of one 10-bit LFSR between N_REQ consumers.
//             Optional post-seed warm-up enabled by macro RNG_WARMUP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module rng_share_arb
    import rng_pkg::*;
#(
    parameter int               N_REQ         = 4,
    parameter int               WIDTH         = RNG_WIDTH,
    parameter logic [WIDTH-1:0] SEED          = RNG_SEED_DEFAULT,
    parameter int               WARMUP_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [WIDTH-1:0] rand_out,
    input  logic             seed_load,
    input  logic [WIDTH-1:0] seed_val,
    output logic             rng_ready
);

    localparam int c_ptr_w = $clog2(N_REQ);

`ifdef RNG_WARMUP_EN
    localparam state_t c_post_seed_state = (WARMUP_CYCLES > 0) ? WARM : RUN;
    localparam int     c_cnt_w = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [c_cnt_w-1:0] c_warm_init = c_cnt_w'(WARMUP_CYCLES);
    logic [c_cnt_w-1:0] r_warm_cnt;
`else
    localparam state_t c_post_seed_state = RUN;
`endif

    state_t               r_state;
    state_t               w_state_next;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_ptr_w-1:0]   w_ptr_next;
    logic [c_ptr_w-1:0]   w_winner;
    logic [c_ptr_w:0]     w_idx;
    logic                 w_found;
    logic                 w_grant;
    logic                 w_step;
    logic [N_REQ-1:0]     w_gnt_next;
    logic [WIDTH-1:0]     w_q;

    lfsr_core #(
        .WIDTH (WIDTH),
        .SEED  (SEED)
    ) u_lfsr (
        .clk      (clk),
        .reset    (reset),
        .step_en  (w_step),
        .load_en  (seed_load),
        .load_val (seed_val),
        .q        (w_q)
    );

    // Masked priority encoder: first set request at or after the pointer, wrapping
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = {1'b0, r_ptr} + (c_ptr_w + 1)'(i);
            if (w_idx >= (c_ptr_w + 1)'(N_REQ)) begin
                w_idx = w_idx - (c_ptr_w + 1)'(N_REQ);
            end
            if (!w_found && req[w_idx[c_ptr_w-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[c_ptr_w-1:0];
            end
        end
    end

    assign w_ptr_next = (w_winner == c_ptr_w'(N_REQ - 1)) ? '0 : w_winner + c_ptr_w'(1);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_post_seed_state;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; seed_load pre-empts everything, including an active reseed
    always_comb begin
        w_state_next = r_state;
        if (seed_load) begin
            w_state_next = RESEED;
        end else begin
            case (r_state)
                RUN:     w_state_next = RUN;
                RESEED:  w_state_next = c_post_seed_state;
`ifdef RNG_WARMUP_EN
                WARM:    w_state_next = (r_warm_cnt <= c_cnt_w'(1)) ? RUN : WARM;
`endif
                default: w_state_next = RUN;
            endcase
        end
    end

    // Output decode
    always_comb begin
        w_grant    = (r_state == RUN) && !seed_load && w_found;
        w_step     = w_grant || (r_state == WARM);
        w_gnt_next = '0;
        if (w_grant) begin
            w_gnt_next[w_winner] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt      <= '0;
            rand_out <= '0;
            r_ptr    <= '0;
        end else begin
            gnt <= w_gnt_next;
            if (w_grant) begin
                rand_out <= w_q;
                r_ptr    <= w_ptr_next;
            end
        end
    end

`ifdef RNG_WARMUP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_warm_cnt <= c_warm_init;
        end else if (w_state_next == WARM && r_state != WARM) begin
            r_warm_cnt <= c_warm_init;
        end else if (r_state == WARM && r_warm_cnt != '0) begin
            r_warm_cnt <= r_warm_cnt - c_cnt_w'(1);
        end
    end
`endif

    assign rng_ready = (r_state == RUN);

endmodule : rng_share_arb
`default_nettype wire
